multicycle_control: RTL and testbench

Multi-cycle control unit for the RV32I datapath, the successor to the single-cycle combinational decoder. A Moore FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB. It drives per-state datapath enables and a request/acknowledge handshake to a variable-latency memory. It also adds opcode classes beyond R/I (load, store, branch), a memory-wait timeout, fault reporting and a retired-instruction counter.

---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/opcode_decoder.sv | 25 ++
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// opcode constants, instruction classes, ALUOp encodings and fault causes.
package cpu_ctrl_pkg;

  // Sequencer states; IDLE must stay the all-zero encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  // RV32I major opcodes handled by this controller.
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Instruction class produced by the opcode decoder.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5
  } opclass_t;

  // ALUOp encodings seen by the ALU control block.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // Fault cause codes reported while the FSM sits in FAULT.
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // Loads and stores are the only classes that visit the MEM state.
  function automatic logic isMemClass(input opclass_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: maps a 7-bit RV32I opcode onto one of
// the instruction classes the controller sequences, flagging anything else.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output opclass_t   o_class,
  output logic       o_illegal
);

  // Classify the opcode; unknown encodings become CLS_NONE with o_illegal set.
  always_comb begin
    o_class   = CLS_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_R:      o_class = CLS_R;
      OPC_I:      o_class = CLS_I;
      OPC_LOAD:   o_class = CLS_LOAD;
      OPC_STORE:  o_class = CLS_STORE;
      OPC_BRANCH: o_class = CLS_BRANCH;
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the RV32I datapath. A Moore FSM walks each
// instruction through FETCH/DECODE/EXECUTE/MEM/WB, handshakes with a
// variable-latency memory, guards memory waits with a timeout, reports
// sticky faults and counts retired instructions.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       opcode_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             mem_to_reg_o,
  output logic             branch_o,
  output logic             fault_o,
  output logic [1:0]       fault_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  // Wide enough to hold MAX_WAIT itself; MAX_WAIT of 0 still gets one bit.
  localparam int WAIT_W = $clog2(MAX_WAIT + 2);

  state_t            r_state;
  logic [6:0]        r_opcode;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CNT_W-1:0]  r_instret;
  logic [1:0]        r_faultCause;

  logic [6:0]        w_decIn;
  opclass_t          w_class;
  logic              w_illegal;
  logic              w_timeout;

  // DECODE classifies the live IR opcode; later states use the latched copy.
  assign w_decIn = (r_state == ST_DECODE) ? opcode_i : r_opcode;

  opcode_decoder u_decoder (
    .i_opcode  (w_decIn),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  // An unacknowledged cycle at MAX_WAIT-1 would bring the counter to MAX_WAIT.
  assign w_timeout = (MAX_WAIT != 0) && (r_waitCnt == WAIT_W'(MAX_WAIT - 1));

  // Sequencer: state, latched opcode, wait counter, fault cause and retire count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_opcode     <= '0;
      r_waitCnt    <= '0;
      r_instret    <= '0;
      r_faultCause <= FC_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state   <= ST_FETCH;
            r_waitCnt <= '0;
          end
        end

        ST_FETCH: begin
          if (mem_ack_i) begin
            r_state <= ST_DECODE;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
            if (w_timeout) begin
              r_state      <= ST_FAULT;
              r_faultCause <= FC_TIMEOUT;
            end
          end
        end

        ST_DECODE: begin
          r_opcode <= opcode_i;
          if (w_illegal) begin
            r_state      <= ST_FAULT;
            r_faultCause <= FC_ILLEGAL;
          end else begin
            r_state <= ST_EXECUTE;
          end
        end

        ST_EXECUTE: begin
          case (w_class)
            CLS_R, CLS_I: r_state <= ST_WB;
            CLS_LOAD, CLS_STORE: begin
              r_state   <= ST_MEM;
              r_waitCnt <= '0;
            end
            CLS_BRANCH: begin
              r_state   <= ST_FETCH;
              r_waitCnt <= '0;
              r_instret <= r_instret + CNT_W'(1);
            end
            default: begin
              r_state      <= ST_FAULT;
              r_faultCause <= FC_ILLEGAL;
            end
          endcase
        end

        ST_MEM: begin
          if (mem_ack_i) begin
            if (w_class == CLS_STORE) begin
              r_state   <= ST_FETCH;
              r_waitCnt <= '0;
              r_instret <= r_instret + CNT_W'(1);
            end else begin
              r_state <= ST_WB;
            end
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
            if (w_timeout) begin
              r_state      <= ST_FAULT;
              r_faultCause <= FC_TIMEOUT;
            end
          end
        end

        ST_WB: begin
          r_state   <= ST_FETCH;
          r_waitCnt <= '0;
          r_instret <= r_instret + CNT_W'(1);
        end

        ST_FAULT: r_state <= ST_FAULT;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore datapath controls; only the FETCH IR/PC strobes follow mem_ack_i.
  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    pc_write_o    = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_o     = 1'b0;
    alu_op_o      = ALUOP_ADD;
    mem_to_reg_o  = 1'b0;
    branch_o      = 1'b0;
    fault_o       = 1'b0;
    fault_cause_o = FC_NONE;
    case (r_state)
      ST_FETCH: begin
        mem_req_o  = 1'b1;
        ir_write_o = mem_ack_i;
        pc_write_o = mem_ack_i;
      end
      ST_EXECUTE: begin
        case (w_class)
          CLS_R: begin
            alu_op_o  = ALUOP_RTYPE;
            alu_src_o = 1'b0;
          end
          CLS_I: begin
            alu_op_o  = ALUOP_ITYPE;
            alu_src_o = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op_o  = ALUOP_ADD;
            alu_src_o = 1'b1;
          end
          CLS_BRANCH: begin
            alu_op_o   = ALUOP_SUB;
            alu_src_o  = 1'b0;
            branch_o   = 1'b1;
            pc_write_o = 1'b1;
          end
          default: alu_op_o = ALUOP_ADD;
        endcase
      end
      ST_MEM: begin
        mem_req_o = isMemClass(w_class);
        mem_we_o  = (w_class == CLS_STORE);
      end
      ST_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (w_class == CLS_LOAD);
      end
      ST_FAULT: begin
        fault_o       = 1'b1;
        fault_cause_o = r_faultCause;
      end
      default: fault_o = 1'b0;
    endcase
  end

  assign instret_o = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A behavioural model expands
// each instruction into its expected per-cycle control trace from the
// instruction class and memory latencies, and tracks the retire count.
module tb_multicycle_control;

  localparam int MAXW = 4;
  localparam int CW   = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic          clk;
  logic          rst;
  logic          start;
  logic          ack;
  logic [6:0]    opc;
  logic          memReq, memWe, pcWrite, irWrite, regWrite, aluSrc;
  logic [1:0]    aluOp;
  logic          memToReg, branch, fault;
  logic [1:0]    faultCause;
  logic [CW-1:0] instret;
  logic [12:0]   actVec;

  int nChecks  = 0;
  int nFails   = 0;
  int modelRet = 0;

  logic [6:0] legalOps [5];

  assign actVec = {memReq, memWe, pcWrite, irWrite, regWrite, aluSrc,
                   aluOp, memToReg, branch, fault, faultCause};

  multicycle_control #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .opcode_i      (opc),
    .mem_ack_i     (ack),
    .mem_req_o     (memReq),
    .mem_we_o      (memWe),
    .pc_write_o    (pcWrite),
    .ir_write_o    (irWrite),
    .reg_write_o   (regWrite),
    .alu_src_o     (aluSrc),
    .alu_op_o      (aluOp),
    .mem_to_reg_o  (memToReg),
    .branch_o      (branch),
    .fault_o       (fault),
    .fault_cause_o (faultCause),
    .instret_o     (instret)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] ev(input logic req, input logic we,
                                     input logic pc, input logic ir,
                                     input logic rw, input logic src,
                                     input logic [1:0] aop, input logic m2r,
                                     input logic br, input logic flt,
                                     input logic [1:0] cause);
    return {req, we, pc, ir, rw, src, aop, m2r, br, flt, cause};
  endfunction

  function automatic bit isLegal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] expVec);
    logic [CW-1:0] expRet;
    expRet = CW'(modelRet % (1 << CW));
    nChecks++;
    assert (actVec === expVec) else begin
      nFails++;
      $error("[TB] FAIL %s: controls observed=%b expected=%b", tag, actVec, expVec);
    end
    nChecks++;
    assert (instret === expRet) else begin
      nFails++;
      $error("[TB] FAIL %s_instret: observed=%0d expected=%0d", tag, instret, expRet);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [6:0] op, input logic a);
    @(negedge clk);
    start = s;
    opc   = op;
    ack   = a;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    ack   = 1'b1;
    opc   = junk();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    #1;
    modelRet = 0;
    checkOutput("reset", '0);
  endtask

  task automatic checkFault(input logic [1:0] cause, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, junk(), rb());
      checkOutput("fault_hold", ev(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, cause));
    end
  endtask

  // Waits in a memory state: n unacknowledged cycles, then optionally an ack.
  task automatic memPhase(input string tag, input logic we, input int waits,
                          input bit finalAck, input bit isFetch);
    for (int k = 0; k < waits; k++) begin
      applyStimulus(rb(), junk(), 1'b0);
      checkOutput({tag, "_wait"}, ev(1, we, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00));
    end
    if (finalAck) begin
      applyStimulus(rb(), junk(), 1'b1);
      checkOutput({tag, "_ack"}, ev(1, we, isFetch, isFetch, 0, 0, 2'b00, 0, 0, 0, 2'b00));
    end
  endtask

  // One instruction from FETCH onwards. fDly/mDly = wait cycles before ack;
  // a delay of MAXW or more times out, a negative mDly abandons MEM early.
  task automatic runInstr(input logic [6:0] op, input int fDly, input int mDly,
                          output bit faulted);
    bit isLoad;
    bit isStore;
    faulted = 1'b0;
    isLoad  = (op == OP_LOAD);
    isStore = (op == OP_STORE);
    if (fDly >= MAXW) begin
      memPhase("fetch", 1'b0, MAXW, 1'b0, 1'b1);
      faulted = 1'b1;
      return;
    end
    memPhase("fetch", 1'b0, fDly, 1'b1, 1'b1);
    applyStimulus(rb(), op, rb());
    checkOutput("decode", '0);
    if (!isLegal(op)) begin
      faulted = 1'b1;
      return;
    end
    applyStimulus(rb(), junk(), rb());
    if (op == OP_R)
      checkOutput("exec_r", ev(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00));
    else if (op == OP_I)
      checkOutput("exec_i", ev(0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 2'b00));
    else if (op == OP_BRANCH)
      checkOutput("exec_br", ev(0, 0, 1, 0, 0, 0, 2'b01, 0, 1, 0, 2'b00));
    else
      checkOutput("exec_mem", ev(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00));
    if (op == OP_BRANCH) begin
      modelRet++;
      return;
    end
    if (isLoad || isStore) begin
      if (mDly < 0) begin
        memPhase("mem", isStore, 2, 1'b0, 1'b0);
        return;
      end
      if (mDly >= MAXW) begin
        memPhase("mem", isStore, MAXW, 1'b0, 1'b0);
        faulted = 1'b1;
        return;
      end
      memPhase("mem", isStore, mDly, 1'b1, 1'b0);
      if (isStore) begin
        modelRet++;
        return;
      end
    end
    applyStimulus(rb(), junk(), rb());
    checkOutput("wb", ev(0, 0, 0, 0, 1, 0, 2'b00, isLoad, 0, 0, 2'b00));
    modelRet++;
  endtask

  initial begin
    bit f;
    logic [6:0] op;
    legalOps = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
    rst   = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    opc   = '0;

    $display("[TB] reset and idle behaviour");
    doReset();
    applyStimulus(1'b0, junk(), 1'b1);
    checkOutput("idle_ack_ignored", '0);
    applyStimulus(1'b0, junk(), 1'b0);
    checkOutput("idle", '0);
    applyStimulus(1'b1, junk(), 1'b0);
    checkOutput("idle_start", '0);

    $display("[TB] directed R, LOAD, STORE, BRANCH");
    runInstr(OP_R, 0, 0, f);
    runInstr(OP_LOAD, 0, 3, f);
    runInstr(OP_STORE, 0, 0, f);
    runInstr(OP_BRANCH, 0, 0, f);

    $display("[TB] random legal instruction stream");
    for (int n = 0; n < 20; n++) begin
      op = legalOps[$urandom_range(0, 4)];
      runInstr(op, int'($urandom_range(0, MAXW - 1)), int'($urandom_range(0, MAXW - 1)), f);
    end

    $display("[TB] fetch timeout");
    runInstr(OP_R, MAXW, 0, f);
    checkFault(2'b10, 3);
    doReset();

    $display("[TB] ack on last allowed wait cycle");
    applyStimulus(1'b1, junk(), 1'b0);
    checkOutput("idle_start", '0);
    runInstr(OP_LOAD, MAXW - 1, MAXW - 1, f);
    runInstr(OP_I, 0, 0, f);

    $display("[TB] memory-stage timeout");
    runInstr(OP_STORE, 0, MAXW, f);
    checkFault(2'b10, 3);
    doReset();

    $display("[TB] illegal opcodes");
    applyStimulus(1'b1, junk(), 1'b0);
    checkOutput("idle_start", '0);
    runInstr(7'b1111111, 0, 0, f);
    checkFault(2'b01, 4);
    doReset();
    applyStimulus(1'b1, junk(), 1'b0);
    checkOutput("idle_start", '0);
    runInstr(OP_BRANCH, 1, 0, f);
    do op = junk(); while (isLegal(op));
    runInstr(op, int'($urandom_range(0, MAXW - 1)), 0, f);
    checkFault(2'b01, 2);
    doReset();

    $display("[TB] reset during a memory request");
    applyStimulus(1'b1, junk(), 1'b0);
    checkOutput("idle_start", '0);
    runInstr(OP_R, 0, 0, f);
    runInstr(OP_LOAD, 1, -1, f);
    doReset();
    applyStimulus(1'b0, junk(), 1'b1);
    checkOutput("idle_after_reset", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
